uart_rx: RTL



---
 rtl/uart_pkg.sv | 30 +++
 rtl/uart_rx_sync.sv | 52 +++++
 rtl/uart_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: constants and types shared by the uart_tx / uart_rx pair.
package uart_pkg;

    // Data bits per frame, sent LSB first. Only 8 is supported.
    localparam int DATA_BITS = 8;

    // parity_sel encodings; 2'b11 behaves like PAR_NONE
    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    // stop_sel encodings
    localparam logic STOP_ONE = 1'b0;
    localparam logic STOP_TWO = 1'b1;

    // Receiver state encoding
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_e;

    // True when the parity selection carries a parity bit on the line
    function automatic logic parity_enabled(input logic [1:0] sel);
        return (sel == PAR_ODD) || (sel == PAR_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: SYNC_STAGES-deep metastability synchroniser for rxd with a
// falling-edge strobe and the per-cycle sample value used by the receiver.
// Optional feature: define UART_RX_MAJORITY_EN to make rx_sample the 2-of-3
// majority of the synchronised line around the current cycle.
module uart_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic mclk,
    input  logic n_reset,
    input  logic rxd,
    output logic rx_fall,
    output logic rx_sample
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   rxd_s;

    assign rxd_s = sync_q[SYNC_STAGES-1];

    // Shift the raw line into the chain; keep last cycle's rxd_s for edge detect
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], rxd};
        prev_d = rxd_s;
    end

    // Register stages; reset to the idle-high line level so reset never looks like an edge
    always_ff @(posedge mclk) begin
        if (!n_reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_fall = prev_q & ~rxd_s;

`ifdef UART_RX_MAJORITY_EN
    // prev_q is rxd_s one cycle ago and the stage feeding rxd_s is its value one
    // cycle ahead, so the vote over mid-1/mid/mid+1 is available at count == mid.
    logic rxd_next;
    assign rxd_next  = sync_q[SYNC_STAGES-2];
    assign rx_sample = (prev_q & rxd_s) | (prev_q & rxd_next) | (rxd_s & rxd_next);
`else
    assign rx_sample = rxd_s;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver, the receive end of the uart_tx link.
// Samples each bit mid-period, checks parity and stop bits, and delivers every
// frame (errored or not) as a one-cycle rx_valid strobe.
// Optional feature: UART_RX_MAJORITY_EN selects 2-of-3 majority sampling
// (implemented in uart_rx_sync); bit timing is unchanged by it.
module uart_rx #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 mclk,
    input  logic                 n_reset,
    input  logic                 rxd,
    input  logic [15:0]          baud_max_cnt,
    input  logic [1:0]           parity_sel,
    input  logic                 stop_sel,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    import uart_pkg::*;

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    rx_state_e            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_acc_q, par_acc_d;
    logic                 frm_acc_q, frm_acc_d;
    logic                 second_q, second_d;
    logic [15:0]          bmc_q, bmc_d;
    logic [1:0]           par_q, par_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q, frame_err_d;

    logic                 rx_fall;
    logic                 rx_sample;
    logic [15:0]          mid_cnt;
    logic                 at_mid;
    logic                 at_end;
    logic                 frm_now;
    logic                 par_bad;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .mclk      (mclk),
        .n_reset   (n_reset),
        .rxd       (rxd),
        .rx_fall   (rx_fall),
        .rx_sample (rx_sample)
    );

    assign mid_cnt = {1'b0, bmc_q[15:1]};
    assign at_mid  = (cnt_q == mid_cnt);
    assign at_end  = (cnt_q == bmc_q);
    assign frm_now = frm_acc_q | ~rx_sample;
    assign par_bad = (par_q == PAR_ODD) ? ~((^shift_q) ^ rx_sample)
                                        :  ((^shift_q) ^ rx_sample);

    // Next-state, bit timing and frame assembly; the counter restarts on every state entry
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 16'd1;
        bit_d        = bit_q;
        shift_d      = shift_q;
        par_acc_d    = par_acc_q;
        frm_acc_d    = frm_acc_q;
        second_d     = second_q;
        bmc_d        = bmc_q;
        par_d        = par_q;
        stop_d       = stop_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_fall) begin
                    state_d   = START;
                    bmc_d     = baud_max_cnt;
                    par_d     = parity_sel;
                    stop_d    = stop_sel;
                    bit_d     = '0;
                    par_acc_d = 1'b0;
                    frm_acc_d = 1'b0;
                    second_d  = 1'b0;
                end
            end

            START: begin
                if (at_mid && rx_sample) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end

            DATA: begin
                if (at_mid) begin
                    shift_d = {rx_sample, shift_q[DATA_BITS-1:1]};
                end
                if (at_end) begin
                    cnt_d = '0;
                    if (bit_q == LAST_BIT) begin
                        state_d = parity_enabled(par_q) ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            PARITY: begin
                if (at_mid) begin
                    par_acc_d = par_bad;
                end
                if (at_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end
            end

            STOP: begin
                if (at_mid) begin
                    frm_acc_d = frm_now;
                    if (stop_q != STOP_TWO || second_q) begin
                        state_d      = IDLE;
                        cnt_d        = '0;
                        rx_valid_d   = 1'b1;
                        rx_data_d    = shift_q;
                        parity_err_d = par_acc_q;
                        frame_err_d  = frm_now;
                    end
                end else if (at_end) begin
                    second_d = 1'b1;
                    cnt_d    = '0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge mclk) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            par_acc_q    <= 1'b0;
            frm_acc_q    <= 1'b0;
            second_q     <= 1'b0;
            bmc_q        <= '0;
            par_q        <= PAR_NONE;
            stop_q       <= STOP_ONE;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            par_acc_q    <= par_acc_d;
            frm_acc_q    <= frm_acc_d;
            second_q     <= second_d;
            bmc_q        <= bmc_d;
            par_q        <= par_d;
            stop_q       <= stop_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule
